// File: rtl/camera_pkg.sv
// Shared camera-board definitions: SRAM geometry and the
// state encoding of the SRAM port arbiter.
package camera_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      TURN   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: two command
// ports plus the shared read-data return.
interface sram_port_arbiter_if;
   import camera_pkg::*;

   logic                   p0_req;
   logic                   p0_we;
   logic [SRAM_ADDR_W-1:0] p0_addr;
   logic [SRAM_DATA_W-1:0] p0_wdata;
   logic                   p0_gnt;
   logic                   p0_rvalid;

   logic                   p1_req;
   logic                   p1_we;
   logic [SRAM_ADDR_W-1:0] p1_addr;
   logic [SRAM_DATA_W-1:0] p1_wdata;
   logic                   p1_gnt;
   logic                   p1_rvalid;

   logic [SRAM_DATA_W-1:0] rdata;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p0_gnt, p0_rvalid,
      input  p1_gnt, p1_rvalid,
      input  rdata
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p0_gnt, p0_rvalid,
      output p1_gnt, p1_rvalid,
      output rdata
   );

endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter and strobe sequencer for the asynchronous
// SRAM; port 0 has priority bounded by a starvation guard.
module sram_port_arbiter
   import camera_pkg::*;
#(
   parameter int ACCESS_CYCLES = 2,
   parameter int P0_MAX_RUN    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   sram_port_arbiter_if.slave     bus,
   output logic                   s1_OE,
   output logic                   s1_WE,
   output logic [SRAM_ADDR_W-1:0] s1_Addr,
   output logic [SRAM_DATA_W-1:0] s1_WD,
   output logic                   s1_WD_oe,
   input  logic [SRAM_DATA_W-1:0] s1_RD
);

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] RUN_MAX  = 4'(P0_MAX_RUN);

   arb_state_t state;
   logic [3:0] acc_cnt;
   logic [3:0] run_cnt;
   logic       own_p1;
   logic       is_wr;

   logic                   any_req;
   logic                   run_at_max;
   logic                   pick_p1;
   logic                   win_we;
   logic [SRAM_ADDR_W-1:0] win_addr;
   logic [SRAM_DATA_W-1:0] win_wdata;

   // Port 1 wins when alone, or when port 0 has used up its run.
   always_comb begin
      any_req    = bus.p0_req | bus.p1_req;
      run_at_max = (run_cnt == RUN_MAX);
      pick_p1    = bus.p1_req & (~bus.p0_req | run_at_max);
      win_we     = pick_p1 ? bus.p1_we    : bus.p0_we;
      win_addr   = pick_p1 ? bus.p1_addr  : bus.p0_addr;
      win_wdata  = pick_p1 ? bus.p1_wdata : bus.p0_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         acc_cnt       <= '0;
         run_cnt       <= '0;
         own_p1        <= 1'b0;
         is_wr         <= 1'b0;
         s1_OE         <= 1'b1;
         s1_WE         <= 1'b1;
         s1_WD_oe      <= 1'b0;
         s1_Addr       <= '0;
         s1_WD         <= '0;
         bus.rdata     <= '0;
         bus.p0_gnt    <= 1'b0;
         bus.p1_gnt    <= 1'b0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
      end else begin
         bus.p0_gnt    <= 1'b0;
         bus.p1_gnt    <= 1'b0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  s1_Addr    <= win_addr;
                  s1_WD      <= win_wdata;
                  s1_OE      <= win_we;
                  s1_WE      <= ~win_we;
                  s1_WD_oe   <= win_we;
                  own_p1     <= pick_p1;
                  is_wr      <= win_we;
                  acc_cnt    <= CNT_LOAD;
                  bus.p0_gnt <= ~pick_p1;
                  bus.p1_gnt <= pick_p1;
                  if (pick_p1)
                     run_cnt <= '0;
                  else if (bus.p1_req && !run_at_max)
                     run_cnt <= run_cnt + 4'd1;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (acc_cnt == '0) begin
                  s1_OE <= 1'b1;
                  s1_WE <= 1'b1;
                  if (is_wr) begin
                     // Data stays driven one cycle past WE for hold.
                     state <= TURN;
                  end else begin
                     bus.rdata     <= s1_RD;
                     bus.p0_rvalid <= ~own_p1;
                     bus.p1_rvalid <= own_p1;
                     state         <= IDLE;
                  end
               end else begin
                  acc_cnt <= acc_cnt - 4'd1;
               end
            end
            TURN: begin
               s1_WD_oe <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: SRAM models behind
// two instances (ACCESS_CYCLES 2 and 1).
module tb_sram_port_arbiter;
   import camera_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // instance A: ACCESS_CYCLES = 2, P0_MAX_RUN = 4
   sram_port_arbiter_if bus();
   logic                   s1_OE, s1_WE, s1_WD_oe;
   logic [SRAM_ADDR_W-1:0] s1_Addr;
   logic [SRAM_DATA_W-1:0] s1_WD;
   logic [SRAM_DATA_W-1:0] s1_RD = '0;

   sram_port_arbiter #(.ACCESS_CYCLES(2), .P0_MAX_RUN(4)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .s1_OE(s1_OE), .s1_WE(s1_WE), .s1_Addr(s1_Addr),
      .s1_WD(s1_WD), .s1_WD_oe(s1_WD_oe), .s1_RD(s1_RD)
   );

   // instance B: ACCESS_CYCLES = 1
   sram_port_arbiter_if bus1();
   logic                   s1b_OE, s1b_WE, s1b_WD_oe;
   logic [SRAM_ADDR_W-1:0] s1b_Addr;
   logic [SRAM_DATA_W-1:0] s1b_WD;
   logic [SRAM_DATA_W-1:0] s1b_RD = '0;

   sram_port_arbiter #(.ACCESS_CYCLES(1), .P0_MAX_RUN(4)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .s1_OE(s1b_OE), .s1_WE(s1b_WE), .s1_Addr(s1b_Addr),
      .s1_WD(s1b_WD), .s1_WD_oe(s1b_WD_oe), .s1_RD(s1b_RD)
   );

   logic [31:0] mem0 [logic [17:0]];
   logic [31:0] mem1 [logic [17:0]];

   function automatic logic [31:0] pat(input logic [17:0] a);
      return {14'h1B3, a};
   endfunction

   function automatic logic [31:0] rd0(input logic [17:0] a);
      return mem0.exists(a) ? mem0[a] : pat(a);
   endfunction

   function automatic logic [31:0] rd1(input logic [17:0] a);
      return mem1.exists(a) ? mem1[a] : pat(a);
   endfunction

   // SRAM models: drive RD mid-cycle while OE is low, store while WE is low
   always @(negedge clk) begin
      s1_RD  <= (s1_OE === 1'b0) ? rd0(s1_Addr) : 32'h0;
      s1b_RD <= (s1b_OE === 1'b0) ? rd1(s1b_Addr) : 32'h0;
      if (s1_WE === 1'b0 && s1_WD_oe === 1'b1)
         mem0[s1_Addr] = s1_WD;
      if (s1b_WE === 1'b0 && s1b_WD_oe === 1'b1)
         mem1[s1b_Addr] = s1b_WD;
   end

   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   logic [31:0] exp1b[$];
   int rv0 = 0, rv1 = 0, rv1b = 0;
   int oe_run = 0, last_oe_len = 0;
   int we_run = 0, last_we_len = 0;
   int addr_bad = 0;
   int max_run = 0;
   logic [17:0] strobe_addr;

   always @(negedge clk) begin
      logic [31:0] e;
      if (bus.p0_rvalid === 1'b1) begin
         rv0++;
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("FAIL p0_rvalid unexpected: rdata=%h", bus.rdata);
         end else begin
            e = exp0.pop_front();
            if (bus.rdata !== e) begin
               errors++;
               $display("FAIL p0_rdata: got %h want %h", bus.rdata, e);
            end
         end
      end
      if (bus.p1_rvalid === 1'b1) begin
         rv1++;
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("FAIL p1_rvalid unexpected: rdata=%h", bus.rdata);
         end else begin
            e = exp1.pop_front();
            if (bus.rdata !== e) begin
               errors++;
               $display("FAIL p1_rdata: got %h want %h", bus.rdata, e);
            end
         end
      end
      if (bus1.p1_rvalid === 1'b1) begin
         rv1b++;
         checks++;
         if (exp1b.size() == 0) begin
            errors++;
            $display("FAIL b2b_rvalid unexpected: rdata=%h", bus1.rdata);
         end else begin
            e = exp1b.pop_front();
            if (bus1.rdata !== e) begin
               errors++;
               $display("FAIL b2b_rdata: got %h want %h", bus1.rdata, e);
            end
         end
      end
      // strobe widths and address stability on instance A
      if (s1_OE === 1'b0) begin
         if (oe_run == 0) strobe_addr = s1_Addr;
         else if (s1_Addr !== strobe_addr) addr_bad++;
         oe_run++;
      end else if (oe_run != 0) begin
         last_oe_len = oe_run;
         oe_run = 0;
      end
      if (s1_WE === 1'b0) begin
         if (we_run == 0) strobe_addr = s1_Addr;
         else if (s1_Addr !== strobe_addr) addr_bad++;
         we_run++;
      end else if (we_run != 0) begin
         last_we_len = we_run;
         we_run = 0;
      end
      if (int'(dut.run_cnt) > max_run) max_run = int'(dut.run_cnt);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit p, input bit we,
                         input logic [17:0] a, input logic [31:0] d,
                         output int gcyc);
      gcyc = -1;
      if (!p) begin
         bus.p0_req = 1'b1; bus.p0_we = we;
         bus.p0_addr = a;   bus.p0_wdata = d;
      end else begin
         bus.p1_req = 1'b1; bus.p1_we = we;
         bus.p1_addr = a;   bus.p1_wdata = d;
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if ((p ? bus.p1_gnt : bus.p0_gnt) === 1'b1) begin
            gcyc = cyc;
            break;
         end
      end
      if (!p) bus.p0_req = 1'b0;
      else    bus.p1_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (s1_OE !== 1'b1 || s1_WE !== 1'b1 || s1_WD_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: oe=%b we=%b wdoe=%b want 1 1 0",
                  s1_OE, s1_WE, s1_WD_oe);
      end
      checks++;
      if (s1_Addr !== 18'h0 || s1_WD !== 32'h0 || bus.rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wd=%h rdata=%h want 0",
                  s1_Addr, s1_WD, bus.rdata);
      end
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b want 0000",
                  {bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      int g;
      int r0 = rv1;
      mem0[18'h00010] = 32'hDEADBEEF;
      exp1.push_back(32'hDEADBEEF);
      do_req(1'b1, 1'b0, 18'h00010, 32'h0, g);
      checks++;
      if (g < 0) begin
         errors++;
         $display("FAIL read_gnt: got none want p1_gnt");
      end
      checks++;
      if (s1_OE !== 1'b0 || s1_Addr !== 18'h00010) begin
         errors++;
         $display("FAIL read_strobe1: oe=%b addr=%h want 0 00010", s1_OE, s1_Addr);
      end
      tick();
      checks++;
      if (s1_OE !== 1'b0 || bus.p1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL read_strobe2: oe=%b gnt=%b want 0 0", s1_OE, bus.p1_gnt);
      end
      tick();
      checks++;
      if (s1_OE !== 1'b1 || bus.p1_rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_done: oe=%b rvalid=%b rdata=%h want 1 1 deadbeef",
                  s1_OE, bus.p1_rvalid, bus.rdata);
      end
      tick();
      checks++;
      if (last_oe_len != 2 || rv1 != r0 + 1 || addr_bad != 0) begin
         errors++;
         $display("FAIL read_window: oe_len=%0d rv=%0d addr_bad=%0d want 2 %0d 0",
                  last_oe_len, rv1 - r0, addr_bad, 1);
      end
   endtask

   task automatic test_write();
      int g1 = -1, g2 = -1;
      int r0 = rv1;
      bus.p0_req = 1'b1; bus.p0_we = 1'b1;
      bus.p0_addr = 18'h3FFFF; bus.p0_wdata = 32'h12345678;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.p0_gnt === 1'b1) begin g1 = cyc; break; end
      end
      bus.p0_req = 1'b0;
      checks++;
      if (g1 < 0 || s1_WE !== 1'b0 || s1_OE !== 1'b1 || s1_WD_oe !== 1'b1
          || s1_WD !== 32'h12345678) begin
         errors++;
         $display("FAIL write_start: g=%0d we=%b oe=%b wdoe=%b wd=%h want 0 1 1 12345678",
                  g1, s1_WE, s1_OE, s1_WD_oe, s1_WD);
      end
      exp1.push_back(32'h12345678);
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 18'h3FFFF;
      tick();
      tick();
      checks++;
      if (s1_WE !== 1'b1 || s1_WD_oe !== 1'b1 || s1_WD !== 32'h12345678
          || bus.p1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL write_hold: we=%b wdoe=%b wd=%h gnt=%b want 1 1 12345678 0",
                  s1_WE, s1_WD_oe, s1_WD, bus.p1_gnt);
      end
      tick();
      checks++;
      if (s1_WD_oe !== 1'b0 || bus.p1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL write_turn: wdoe=%b gnt=%b want 0 0", s1_WD_oe, bus.p1_gnt);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.p1_gnt === 1'b1) begin g2 = cyc; break; end
      end
      bus.p1_req = 1'b0;
      checks++;
      if (g2 - g1 != 4) begin
         errors++;
         $display("FAIL write_spacing: got %0d cycles want 4", g2 - g1);
      end
      checks++;
      if (rd0(18'h3FFFF) !== 32'h12345678 || last_we_len != 2) begin
         errors++;
         $display("FAIL write_model: mem=%h we_len=%0d want 12345678 2",
                  rd0(18'h3FFFF), last_we_len);
      end
      for (int i = 0; i < 20 && rv1 == r0; i++) tick();
      checks++;
      if (rv1 != r0 + 1) begin
         errors++;
         $display("FAIL write_readback: rvalids=%0d want 1", rv1 - r0);
      end
   endtask

   task automatic test_fairness();
      int order[$];
      int want;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      max_run = 0;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 18'h00100;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 18'h00200;
      for (int i = 0; i < 200 && order.size() < 10; i++) begin
         tick();
         if (bus.p0_gnt === 1'b1) begin
            order.push_back(0);
            exp0.push_back(pat(18'h00100));
         end
         if (bus.p1_gnt === 1'b1) begin
            order.push_back(1);
            exp1.push_back(pat(18'h00200));
         end
      end
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      checks++;
      if (order.size() != 10) begin
         errors++;
         $display("FAIL fair_count: got %0d grants want 10", order.size());
      end
      for (int k = 0; k < order.size(); k++) begin
         want = (k % 5 == 4) ? 1 : 0;
         checks++;
         if (order[k] != want) begin
            errors++;
            $display("FAIL fair_order[%0d]: got port %0d want port %0d",
                     k, order[k], want);
         end
      end
      for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++)
         tick();
      checks++;
      if (max_run != 4 || exp0.size() != 0 || exp1.size() != 0) begin
         errors++;
         $display("FAIL fair_drain: max_run=%0d pend0=%0d pend1=%0d want 4 0 0",
                  max_run, exp0.size(), exp1.size());
      end
   endtask

   task automatic test_held_request();
      int g0;
      int waits = 0, gnts = 0;
      int r0 = rv1;
      do_req(1'b0, 1'b1, 18'h00050, 32'hCAFE0050, g0);
      exp1.push_back(pat(18'h00060));
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 18'h00060;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (bus.p1_gnt === 1'b1) begin
            gnts++;
            bus.p1_req = 1'b0;
         end else if (bus.p1_req === 1'b1) begin
            waits++;
         end
      end
      bus.p1_req = 1'b0;
      checks++;
      if (g0 < 0 || gnts != 1 || waits != 3) begin
         errors++;
         $display("FAIL held_gnt: g0=%0d gnts=%0d waits=%0d want 1 gnt 3 waits",
                  g0, gnts, waits);
      end
      checks++;
      if (rv1 != r0 + 1) begin
         errors++;
         $display("FAIL held_rvalid: got %0d want 1", rv1 - r0);
      end
   endtask

   task automatic test_reset_mid_access();
      int g;
      int r0 = rv1;
      do_req(1'b1, 1'b0, 18'h00020, 32'h0, g);
      reset = 1'b1;
      tick();
      checks++;
      if (g < 0 || s1_OE !== 1'b1 || s1_WE !== 1'b1 || s1_WD_oe !== 1'b0
          || s1_Addr !== 18'h0) begin
         errors++;
         $display("FAIL midreset_outputs: g=%0d oe=%b we=%b wdoe=%b addr=%h want 1 1 0 0",
                  g, s1_OE, s1_WE, s1_WD_oe, s1_Addr);
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (rv1 != r0) begin
         errors++;
         $display("FAIL midreset_dropped: rvalids=%0d want 0", rv1 - r0);
      end
      exp1.push_back(pat(18'h00020));
      do_req(1'b1, 1'b0, 18'h00020, 32'h0, g);
      for (int i = 0; i < 20 && rv1 == r0; i++) tick();
      checks++;
      if (g < 0 || rv1 != r0 + 1) begin
         errors++;
         $display("FAIL midreset_fresh: g=%0d rvalids=%0d want 1", g, rv1 - r0);
      end
   endtask

   task automatic test_back_to_back();
      int g1 = -1, g2 = -1;
      int r0 = rv1b;
      mem1[18'h0] = 32'hA5A50001;
      mem1[18'h1] = 32'h5A5A0002;
      exp1b.push_back(32'hA5A50001);
      bus1.p1_req = 1'b1; bus1.p1_we = 1'b0; bus1.p1_addr = 18'h0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus1.p1_gnt === 1'b1) begin g1 = cyc; break; end
      end
      exp1b.push_back(32'h5A5A0002);
      bus1.p1_addr = 18'h1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus1.p1_gnt === 1'b1) begin g2 = cyc; break; end
      end
      bus1.p1_req = 1'b0;
      checks++;
      if (g1 < 0 || g2 - g1 != 2 || s1b_Addr !== 18'h1) begin
         errors++;
         $display("FAIL b2b_spacing: gap=%0d addr=%h want 2 00001", g2 - g1, s1b_Addr);
      end
      for (int i = 0; i < 20 && rv1b < r0 + 2; i++) tick();
      checks++;
      if (rv1b != r0 + 2 || exp1b.size() != 0) begin
         errors++;
         $display("FAIL b2b_rvalids: got %0d pend=%0d want 2 0",
                  rv1b - r0, exp1b.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
      bus1.p0_req = 1'b0; bus1.p0_we = 1'b0; bus1.p0_addr = '0; bus1.p0_wdata = '0;
      bus1.p1_req = 1'b0; bus1.p1_we = 1'b0; bus1.p1_addr = '0; bus1.p1_wdata = '0;
      test_reset();
      test_single_read();
      test_write();
      test_fairness();
      test_held_request();
      test_reset_mid_access();
      test_back_to_back();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and access sequencer for the camera board's single asynchronous SRAM port (s1). The capture writer (port 0) and the dump sequencer (port 1) share the SRAM through this block; it serialises requests, generates the active-low strobes with the configured access time, and returns read data. Port 0 has fixed priority, bounded by a starvation guard so dumps progress while capture is active.

## Interface
- ACCESS_CYCLES, 2, cycles the strobe (s1_OE or s1_WE) is held low per access; legal range 1..15
- P0_MAX_RUN, 4, consecutive port-0 grants allowed while port 1 is waiting; legal range 1..15
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  request; held with its command until gnt is seen
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  18  word address
- p0_wdata, p1_wdata  in  32  write data
- p0_gnt, p1_gnt  out  1  one-cycle pulse; command accepted
- p0_rvalid, p1_rvalid  out  1  one-cycle pulse; read data valid
- rdata  out  32  read data; shared by both ports, qualified by px_rvalid
- s1_OE  out  1  SRAM output enable, active low
- s1_WE  out  1  SRAM write enable, active low
- s1_Addr  out  18  SRAM address
- s1_WD  out  32  SRAM write data
- s1_WD_oe  out  1  data-bus drive enable for the top-level tristate
- s1_RD  in  32  SRAM read data

## Operation
- States: IDLE, ACCESS, TURN.
- IDLE: when any req is high at the clock edge, select the winner and then:
  - latch the winner's addr, we and wdata onto s1_Addr, s1_WE/s1_OE and s1_WD;
  - drive s1_OE low for a read, or s1_WE low plus s1_WD_oe high for a write;
  - load the access counter with ACCESS_CYCLES-1, pulse the winner's gnt, and go to ACCESS.
- Selection:
  - only p0_req high: port 0 wins;
  - only p1_req high: port 1 wins;
  - both high: port 0 wins unless run_cnt == P0_MAX_RUN, in which case port 1 wins.
- run_cnt (4 bits):
  - increments when port 0 wins while p1_req is high;
  - clears when port 1 wins;
  - holds otherwise;
  - saturates at P0_MAX_RUN.
- ACCESS: the counter decrements each cycle. At the edge where it equals 0:
  - both strobes go high;
  - read: capture s1_RD into rdata, pulse the owner's rvalid, go to IDLE;
  - write: keep s1_WD and s1_WD_oe for one more cycle (hold time), go to TURN.
- TURN: s1_WD_oe goes low, then go to IDLE.
- s1_Addr and rdata hold their last values between accesses.
- A request is never sampled outside IDLE, and the gnt pulse ends before the next IDLE sample, so a held request is never double-accepted.
- Reset asserted mid-access: everything returns to reset values on the next edge. The in-flight access is dropped, with no rvalid and no retry.
- Reset values:
  - s1_OE = 1, s1_WE = 1, s1_WD_oe = 0;
  - s1_Addr = 0, s1_WD = 0, rdata = 0;
  - all gnt and rvalid = 0;
  - state IDLE, run_cnt 0.

## Timing
- Let E0 be the edge that accepts a request.
  - gnt is high for the cycle after E0.
  - The strobe is low for exactly ACCESS_CYCLES cycles.
- Read:
  - s1_RD is sampled at edge E0+ACCESS_CYCLES;
  - rvalid and rdata are valid for the one cycle after that edge.
- Back-to-back throughput:
  - reads: 1 + ACCESS_CYCLES cycles per access;
  - writes: 2 + ACCESS_CYCLES cycles per access.
- s1_Addr is stable for the whole strobe-low window. On writes, s1_WD is stable from the strobe falling until one cycle after it rises.
- All outputs are registered; there is no combinational path from req to any output.

## Structure
- Shared package camera_pkg holds:
  - SRAM_ADDR_W = 18 and SRAM_DATA_W = 32;
  - the arbiter state encoding (IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2).
- No sub-module: the picker and run counter are small and stay inline. The tristate buffer lives in the top level, driven by s1_WD_oe.

## Test plan
- Single port-1 read of addr 0x00010, SRAM model returning 0xDEADBEEF, ACCESS_CYCLES = 2 -> p1_gnt pulses after E0; s1_OE is low for 2 cycles with s1_Addr = 0x00010; p1_rvalid pulses 2 cycles after p1_gnt with rdata = 0xDEADBEEF.
- Port-0 write of 0x12345678 to 0x3FFFF -> s1_WE is low for 2 cycles; s1_WD_oe stays high 1 cycle after s1_WE rises; the model holds 0x12345678 at 0x3FFFF; the next acceptance is no earlier than 4 cycles after E0.
- Both ports requesting continuously with P0_MAX_RUN = 4 -> grant order is 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, and so on; run_cnt never exceeds 4.
- p1_req held high across 3 gnt-free cycles while port 0 is busy -> exactly one p1_gnt and exactly one p1_rvalid for that request.
- Reset pulsed in the middle of a read's ACCESS state -> the next edge has s1_OE = 1, s1_WE = 1 and s1_WD_oe = 0; no rvalid ever appears for that read; a fresh request after reset completes normally.
- ACCESS_CYCLES = 1 back-to-back reads at 0x0 and 0x1 -> p1_gnt pulses are 2 cycles apart, and rdata returns the two model words in order.
